// File: rtl/heater_duty_scheduler_pkg.sv
// Shared encodings, widths and saturation helpers for the heater duty scheduler.
package heater_duty_scheduler_pkg;

   localparam int TEMP_W         = 16;
   localparam int CALC_W         = 24;
   localparam int PWM_PERIOD_DEF = 1011;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_PREHEAT  = 2'd1;
   localparam logic [1:0] ST_REGULATE = 2'd2;
   localparam logic [1:0] ST_FAULT    = 2'd3;

   // Symmetric saturation to +/-lim.
   function automatic logic signed [CALC_W-1:0] sat_sym(
      input logic signed [CALC_W-1:0] v,
      input logic signed [CALC_W-1:0] lim
   );
      logic signed [CALC_W-1:0] r;
      if (v > lim)
         r = lim;
      else if (v < -lim)
         r = -lim;
      else
         r = v;
      return r;
   endfunction

   // Clamp to [0, hi] and narrow to the PWM compare width.
   function automatic logic [TEMP_W-1:0] clamp_duty(
      input logic signed [CALC_W-1:0] v,
      input logic signed [CALC_W-1:0] hi
   );
      logic signed [CALC_W-1:0] r;
      if (v[CALC_W-1])
         r = '0;
      else if (v > hi)
         r = hi;
      else
         r = v;
      return TEMP_W'(r);
   endfunction

endpackage

// File: rtl/heater_duty_scheduler_pi_duty_calc.sv
// Two-stage PI duty pipeline: stage 1 registers error and saturated integrator,
// stage 2 forms the clamped duty that the top level captures into high_len.
module heater_duty_scheduler_pi_duty_calc
   import heater_duty_scheduler_pkg::*;
#(
   parameter int KP_SHIFT  = 2,
   parameter int KI_SHIFT  = 6,
   parameter int INTEG_LIM = 32000,
   parameter int DUTY_MAX  = 1010
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_valid,
   input  logic               i_flush,
   input  logic               i_clear,
   input  logic signed [15:0] i_setpoint,
   input  logic signed [15:0] i_temp,
   output logic        [15:0] o_duty,
   output logic               o_valid
);

   localparam logic signed [CALC_W-1:0] LIM = CALC_W'(INTEG_LIM);
   localparam logic signed [CALC_W-1:0] HI  = CALC_W'(DUTY_MAX);

   logic signed [16:0]       w_err;
   logic signed [CALC_W-1:0] w_integ_sum;
   logic signed [CALC_W-1:0] w_integ_nxt;
   logic signed [CALC_W-1:0] w_err_ext;
   logic signed [CALC_W-1:0] w_duty_raw;

   logic signed [16:0]       r_err;
   logic signed [CALC_W-1:0] r_integ;
   logic                     r_s1_valid;

   assign w_err       = {i_setpoint[15], i_setpoint} - {i_temp[15], i_temp};
   assign w_integ_sum = r_integ + {{(CALC_W-17){w_err[16]}}, w_err};
   assign w_integ_nxt = sat_sym(w_integ_sum, LIM);

   assign w_err_ext   = {{(CALC_W-17){r_err[16]}}, r_err};
   assign w_duty_raw  = (w_err_ext >>> KP_SHIFT) + (r_integ >>> KI_SHIFT);

   assign o_duty      = clamp_duty(w_duty_raw, HI);
   assign o_valid     = r_s1_valid;

   // Stage 1: capture error, accumulate integrator; flush drops the in-flight result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err      <= '0;
         r_integ    <= '0;
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= i_valid && !i_flush;
         if (i_clear)
            r_integ <= '0;
         else if (i_valid)
            r_integ <= w_integ_nxt;
         if (i_valid)
            r_err <= w_err;
      end
   end

endmodule

// File: rtl/heater_duty_scheduler.sv
// Heater loop sequencer: preheat, PI regulation, over-temperature and sample-timeout faults.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  IDLE     | heater off, integrator held at zero, waiting for enable
//  PREHEAT  | heater full on until temp is within the band of setpoint
//  REGULATE | heater driven by the PI duty pipeline
//  FAULT    | heater off, sticky until fault_clr with enable low
module heater_duty_scheduler
   import heater_duty_scheduler_pkg::*;
#(
   parameter int PWM_PERIOD     = PWM_PERIOD_DEF,
   parameter int KP_SHIFT       = 2,
   parameter int KI_SHIFT       = 6,
   parameter int INTEG_LIM      = 32000,
   parameter int PREHEAT_BAND   = 50,
   parameter int TEMP_MAX       = 1200,
   parameter int SAMPLE_TIMEOUT = 5000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic signed [15:0] setpoint,
   input  logic signed [15:0] temp_data,
   input  logic               temp_valid,
   input  logic               fault_clr,
   output logic               heater_open,
   output logic signed [15:0] high_len,
   output logic        [1:0]  state,
   output logic               fault
);

   localparam int                 TMO_W      = $clog2(SAMPLE_TIMEOUT + 1);
   localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(SAMPLE_TIMEOUT - 1);
   localparam logic signed [16:0] TEMP_MAX_S = 17'(TEMP_MAX);
   localparam logic signed [16:0] BAND_S     = 17'(PREHEAT_BAND);
   localparam logic [15:0]        DUTY_MAX   = 16'(PWM_PERIOD - 1);

   logic [1:0]         r_state;
   logic [TMO_W-1:0]   r_tmo;
   logic               r_heater_open;
   logic [15:0]        r_high_len;
   logic               r_fault;

   logic [1:0]         w_next;
   logic               w_active;
   logic signed [16:0] w_temp17;
   logic signed [16:0] w_band17;
   logic               w_overtemp;
   logic               w_tmo_hit;
   logic               w_band_ok;
   logic               w_accept;
   logic               w_flush;
   logic               w_clear;
   logic [15:0]        w_duty;
   logic               w_duty_valid;

   assign w_active   = (r_state == ST_PREHEAT) || (r_state == ST_REGULATE);
   assign w_temp17   = {temp_data[15], temp_data};
   assign w_band17   = {setpoint[15], setpoint} - BAND_S;
   assign w_overtemp = w_active && temp_valid && (w_temp17 >= TEMP_MAX_S);
   // Trip lands on the edge where the count would reach SAMPLE_TIMEOUT.
   assign w_tmo_hit  = w_active && !temp_valid && (r_tmo == TMO_LAST);
   assign w_band_ok  = w_temp17 >= w_band17;

   // Next state: fault conditions beat an enable drop, which beats normal progress.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable)
               w_next = ST_PREHEAT;
         end
         ST_PREHEAT: begin
            if (w_overtemp || w_tmo_hit)
               w_next = ST_FAULT;
            else if (!enable)
               w_next = ST_IDLE;
            else if (temp_valid && w_band_ok)
               w_next = ST_REGULATE;
         end
         ST_REGULATE: begin
            if (w_overtemp || w_tmo_hit)
               w_next = ST_FAULT;
            else if (!enable)
               w_next = ST_IDLE;
         end
         ST_FAULT: begin
            if (fault_clr && !enable)
               w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Only samples that keep us in REGULATE feed the PI loop; the preheat-exit sample does not.
   assign w_accept = temp_valid && (r_state == ST_REGULATE) && (w_next == ST_REGULATE);
   assign w_flush  = (w_next != ST_REGULATE);
   assign w_clear  = (r_state != ST_REGULATE) || w_flush;

   heater_duty_scheduler_pi_duty_calc #(
      .KP_SHIFT  (KP_SHIFT),
      .KI_SHIFT  (KI_SHIFT),
      .INTEG_LIM (INTEG_LIM),
      .DUTY_MAX  (PWM_PERIOD - 1)
   ) u_pi (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (w_accept),
      .i_flush    (w_flush),
      .i_clear    (w_clear),
      .i_setpoint (setpoint),
      .i_temp     (temp_data),
      .o_duty     (w_duty),
      .o_valid    (w_duty_valid)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // Sample watchdog: counts only while heating, restarts on every sample and on preheat entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_tmo <= '0;
      else if (!w_active || temp_valid)
         r_tmo <= '0;
      else
         r_tmo <= r_tmo + TMO_W'(1);
   end

   // Output registers follow the next state so they change together with state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_heater_open <= 1'b0;
         r_high_len    <= '0;
         r_fault       <= 1'b0;
      end else begin
         r_heater_open <= (w_next == ST_PREHEAT) || (w_next == ST_REGULATE);
         r_fault       <= (w_next == ST_FAULT);
         case (w_next)
            ST_PREHEAT:  r_high_len <= DUTY_MAX;
            ST_REGULATE: if (w_duty_valid) r_high_len <= w_duty;
            default:     r_high_len <= '0;
         endcase
      end
   end

   assign state       = r_state;
   assign heater_open = r_heater_open;
   assign high_len    = r_high_len;
   assign fault       = r_fault;

endmodule

// File: tb/tb_heater_duty_scheduler.sv
// Self-checking bench for heater_duty_scheduler: directed scenarios plus randomized
// segments, all compared against a behavioural model of the control loop.
module tb_heater_duty_scheduler;

   localparam int TMO    = 100;
   localparam int PWM    = 1011;
   localparam int LIMI   = 32000;
   localparam int TMAX   = 1200;
   localparam int BAND   = 50;

   logic               clk;
   logic               rst_n;
   logic               enable;
   logic signed [15:0] setpoint;
   logic signed [15:0] temp_data;
   logic               temp_valid;
   logic               fault_clr;
   logic               heater_open;
   logic signed [15:0] high_len;
   logic [1:0]         state;
   logic               fault;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model: 0 idle, 1 preheat, 2 regulate, 3 fault
   int m_mode, m_integ, m_idle, m_high, m_cyc;
   int pend_due[$];
   int pend_duty[$];

   heater_duty_scheduler #(
      .PWM_PERIOD     (PWM),
      .KP_SHIFT       (2),
      .KI_SHIFT       (6),
      .INTEG_LIM      (LIMI),
      .PREHEAT_BAND   (BAND),
      .TEMP_MAX       (TMAX),
      .SAMPLE_TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .setpoint    (setpoint),
      .temp_data   (temp_data),
      .temp_valid  (temp_valid),
      .fault_clr   (fault_clr),
      .heater_open (heater_open),
      .high_len    (high_len),
      .state       (state),
      .fault       (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      n_checks++;
      if (obs !== 32'(exp)) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, $signed(obs), exp, $time);
      end
   endtask

   function automatic int fdiv(input int a, input int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   function automatic int lim(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      m_mode  = 0;
      m_integ = 0;
      m_idle  = 0;
      m_high  = 0;
      pend_due.delete();
      pend_duty.delete();
   endtask

   // Advance the model across one clock edge with the given inputs.
   task automatic model_step(input bit en, input int sp, input bit tv, input int td, input bit fc);
      int  nm;
      int  err;
      int  duty;
      bit  acc;
      nm  = m_mode;
      acc = 1'b0;
      duty = 0;
      m_cyc++;
      case (m_mode)
         0: if (en) begin nm = 1; m_idle = 0; end
         1, 2: begin
            m_idle = tv ? 0 : m_idle + 1;
            if ((tv && td >= TMAX) || m_idle >= TMO) nm = 3;
            else if (!en) nm = 0;
            else if (m_mode == 1) begin
               if (tv && td >= sp - BAND) begin nm = 2; m_integ = 0; end
            end else if (tv) begin
               err     = sp - td;
               m_integ = lim(m_integ + err, -LIMI, LIMI);
               duty    = lim(fdiv(err, 4) + fdiv(m_integ, 64), 0, PWM - 1);
               acc     = 1'b1;
            end
         end
         default: if (fc && !en) nm = 0;
      endcase
      if (nm != 2) begin
         m_integ = 0;
         pend_due.delete();
         pend_duty.delete();
      end
      case (nm)
         1: m_high = PWM - 1;
         2: if (pend_due.size() > 0 && pend_due[0] == m_cyc) begin
               m_high = pend_duty.pop_front();
               void'(pend_due.pop_front());
            end
         default: m_high = 0;
      endcase
      if (acc) begin
         pend_due.push_back(m_cyc + 1);
         pend_duty.push_back(duty);
      end
      m_mode = nm;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_state"}, 32'(state), m_mode);
      chk({tag, "_open"},  32'(heater_open), (m_mode == 1 || m_mode == 2) ? 1 : 0);
      chk({tag, "_high"},  32'(unsigned'(high_len)), m_high);
      chk({tag, "_fault"}, 32'(fault), (m_mode == 3) ? 1 : 0);
   endtask

   // Called at a negedge: apply inputs, cross one posedge, compare at the next negedge.
   task automatic step(input string tag, input bit en, input int sp, input bit tv,
                       input int td, input bit fc);
      enable     = en;
      setpoint   = 16'(sp);
      temp_valid = tv;
      temp_data  = 16'(td);
      fault_clr  = fc;
      model_step(en, sp, tv, td, fc);
      @(posedge clk);
      @(negedge clk);
      check_outputs(tag);
   endtask

   initial begin
      int sp_r, vprob;
      bit en_r;
      rst_n      = 1'b0;
      enable     = 1'b0;
      setpoint   = '0;
      temp_data  = '0;
      temp_valid = 1'b0;
      fault_clr  = 1'b0;
      m_cyc      = 0;
      model_reset();
      #12;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // enable -> preheat full on
      step("t1", 1, 800, 0, 200, 0);
      chk("t1_high_const", 32'(unsigned'(high_len)), 1010);
      // preheat exit, then first regulated sample
      step("t2a", 1, 800, 1, 760, 0);
      chk("t2_state_const", 32'(state), 2);
      step("t2b", 1, 800, 1, 760, 0);
      step("t2c", 1, 800, 0, 0, 0);
      chk("t2_duty_const", 32'(unsigned'(high_len)), 10);
      // over-temperature trip and clear handshake
      step("t3a", 1, 800, 1, 1200, 0);
      chk("t3_fault_const", 32'(fault), 1);
      step("t3b", 1, 800, 0, 0, 1);
      chk("t3_hold_const", 32'(state), 3);
      step("t3c", 0, 800, 0, 0, 1);
      chk("t3_idle_const", 32'(state), 0);

      // sample timeout with a late sample restarting the count
      step("t4_en", 1, 800, 0, 0, 0);
      for (int i = 1; i <= 98; i++) step("t4_wait", 1, 800, 0, 0, 0);
      step("t4_v99", 1, 800, 1, 200, 0);
      for (int i = 1; i <= 99; i++) step("t4_wait2", 1, 800, 0, 0, 0);
      chk("t4_not_yet", 32'(state), 1);
      step("t4_trip", 1, 800, 0, 0, 0);
      chk("t4_tmo_fault", 32'(state), 3);
      step("t4_clr", 0, 800, 0, 0, 1);

      // integrator saturation and clamping at both ends
      step("t5_en", 1, 800, 0, 0, 0);
      step("t5_reg", 1, 800, 1, 780, 0);
      for (int i = 0; i < 20; i++) step("t5_cold", 1, 800, 1, -2000, 0);
      step("t5_gap", 1, 800, 0, 0, 0);
      chk("t5_clamp_hi", 32'(unsigned'(high_len)), 1010);
      for (int i = 0; i < 120; i++) step("t5_hot", 1, 800, 1, 1100, 0);
      step("t5_gap2", 1, 800, 0, 0, 0);
      chk("t5_clamp_lo", 32'(unsigned'(high_len)), 0);

      // enable drop right behind a sample: no late write
      step("t6_s", 1, 800, 1, 700, 0);
      step("t6_drop", 0, 800, 0, 0, 0);
      step("t6_after", 0, 800, 0, 0, 0);
      chk("t6_no_late", 32'(unsigned'(high_len)), 0);

      // asynchronous reset mid-regulate
      step("t7_en", 1, 800, 0, 0, 0);
      step("t7_reg", 1, 800, 1, 790, 0);
      step("t7_s", 1, 800, 1, 600, 0);
      step("t7_s2", 1, 800, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("t7_async");
      @(negedge clk);
      rst_n = 1'b1;

      // randomized segments with varying sample density
      for (int seg = 0; seg < 12; seg++) begin
         case (seg % 4)
            0: vprob = 30;
            1: vprob = 90;
            2: vprob = 1;
            default: vprob = 10;
         endcase
         sp_r = $urandom_range(300, 1000);
         en_r = 1'b1;
         for (int c = 0; c < 250; c++) begin
            int  td;
            bit  tv, fc;
            if ($urandom_range(0, 99) < 3) en_r = ~en_r;
            if ($urandom_range(0, 99) < 2) sp_r = $urandom_range(300, 1000);
            tv = ($urandom_range(0, 99) < vprob);
            td = sp_r - 600 + int'($urandom_range(0, 800));
            if ($urandom_range(0, 199) == 0) td = 1200 + int'($urandom_range(0, 300));
            fc = ($urandom_range(0, 99) < 20);
            step("rnd", en_r, sp_r, tv, td, fc);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
